tube_scroller: RTL and testbench

- Parametrised obstacle (tube) generator for the bird-flying game.
- Scrolls NUM_TUBES tubes leftward at a programmable speed per game tick.
- Respawns each tube at the right edge with a pseudo-random gap height and counts passed tubes as score.
- Sits between the game-tick clock domain logic and the VGA renderer/collision checker; replaces the fixed three-tube, speed-1 scroller.

---
 rtl/tube_pkg.sv | 44 ++++
 rtl/tube_lfsr.sv | 34 +++
 rtl/tube_scroller.sv | 176 +++++++++++++++++
 tb/tb_tube_scroller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared definitions for the tube scroller: default playfield geometry,
// FSM state encoding and LFSR feedback tap masks.
package tube_pkg;

  localparam int DEF_X0        = 320;
  localparam int DEF_SPACING   = 240;
  localparam int DEF_X_RIGHT   = 800;
  localparam int DEF_X_LEFT    = 110;
  localparam int DEF_Y_DEFAULT = 240;
  localparam int DEF_Y_BASE    = 150;

  // Seed loaded on clr; truncated or zero-extended to the LFSR width.
  localparam logic [31:0] LFSR_SEED = 32'h5A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Maximal-length Fibonacci tap masks (bit k = stage k, MSB = stage w-1).
  // Returns 0 for unsupported widths so the instantiating module can flag it.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       return 32'h0003;
      3:       return 32'h0006;
      4:       return 32'h000C;
      5:       return 32'h0014;
      6:       return 32'h0030;
      7:       return 32'h0060;
      8:       return 32'h00B8;
      9:       return 32'h0110;
      10:      return 32'h0240;
      11:      return 32'h0500;
      12:      return 32'h0E08;
      13:      return 32'h1C80;
      14:      return 32'h3802;
      15:      return 32'h6000;
      16:      return 32'hD008;
      default: return 32'h0000;
    endcase
  endfunction

endpackage

// File: rtl/tube_lfsr.sv
// Free-running maximal-length LFSR supplying gap heights. Advances on every
// clk_10 edge outside reset, independent of the game state.
module tube_lfsr
  import tube_pkg::*;
#(
  parameter int RAND_W = 7
) (
  input  logic              clk_10,
  input  logic              clr,
  output logic [RAND_W-1:0] value
);

  localparam logic [RAND_W-1:0] TAPS   = RAND_W'(lfsr_taps(RAND_W));
  localparam logic [RAND_W-1:0] SEED_T = RAND_W'(LFSR_SEED);
  // An all-zero state would lock the register, so fall back to 1.
  localparam logic [RAND_W-1:0] SEED   = (SEED_T == '0) ? RAND_W'(1) : SEED_T;

  logic [RAND_W-1:0] r_state;
  logic              w_fb;

  if (RAND_W < 2 || RAND_W > 16) begin : g_width_chk
    $error("tube_lfsr: RAND_W must be in 2..16");
  end

  assign w_fb  = ^(r_state & TAPS);
  assign value = r_state;

  // Shift left with XOR feedback of the tapped stages.
  always_ff @(posedge clk_10) begin
    if (clr) r_state <= SEED;
    else     r_state <= {r_state[RAND_W-2:0], w_fb};
  end

endmodule

// File: rtl/tube_scroller.sv
// Tube obstacle generator: scrolls NUM_TUBES tubes left by the (effective)
// speed each game tick, respawns them at the right edge with a random gap
// height and counts respawns as score.
// Optional build macro: TUBE_DIFFICULTY_RAMP_EN adds a level register that
// raises the effective speed by one per LEVEL_STEP points.
module tube_scroller
  import tube_pkg::*;
#(
  parameter int NUM_TUBES  = 3,
  parameter int XW         = 10,
  parameter int X0         = DEF_X0,
  parameter int SPACING    = DEF_SPACING,
  parameter int X_RIGHT    = DEF_X_RIGHT,
  parameter int X_LEFT     = DEF_X_LEFT,
  parameter int Y_DEFAULT  = DEF_Y_DEFAULT,
  parameter int Y_BASE     = DEF_Y_BASE,
  parameter int RAND_W     = 7,
  parameter int SPEED_W    = 3,
  parameter int SCORE_W    = 10,
  parameter int LEVEL_STEP = 8
) (
  input  logic                    clk_10,
  input  logic                    clr,
  input  logic                    start,
  input  logic                    over,
  input  logic                    pause,
  input  logic [SPEED_W-1:0]      speed,
  output logic [NUM_TUBES*XW-1:0] x_flat,
  output logic [NUM_TUBES*XW-1:0] y_flat,
  output logic [NUM_TUBES-1:0]    respawn,
  output logic [SCORE_W-1:0]      score,
  output logic                    running
);

  if (Y_BASE + (2**RAND_W) - 1 >= (2**XW)) begin : g_ybase_chk
    $error("tube_scroller: Y_BASE + 2^RAND_W - 1 does not fit in XW bits");
  end
  if (NUM_TUBES < 1 || NUM_TUBES > 8 || LEVEL_STEP < 1) begin : g_param_chk
    $error("tube_scroller: NUM_TUBES must be 1..8 and LEVEL_STEP >= 1");
  end

  state_t                  r_state, w_state_nxt;
  logic                    w_step, w_reinit;
  logic                    r_running;
  logic [XW-1:0]           r_x [NUM_TUBES];
  logic [XW-1:0]           r_y [NUM_TUBES];
  logic [XW-1:0]           w_x_nxt [NUM_TUBES];
  logic [XW-1:0]           w_y_nxt [NUM_TUBES];
  logic [NUM_TUBES-1:0]    r_respawn, w_hit;
  logic [SCORE_W-1:0]      r_score, w_score_nxt;
  logic [SCORE_W+3:0]      w_sum;
  logic [XW:0]             w_lim;
  logic [SPEED_W-1:0]      w_speed;
  logic [RAND_W-1:0]       w_rand;

  // Rotate left by n (mod RAND_W) so tubes respawning together differ.
  function automatic logic [RAND_W-1:0] rotl(input logic [RAND_W-1:0] v, input int n);
    logic [RAND_W-1:0] t;
    t = v;
    for (int k = 0; k < RAND_W; k++)
      if (k < (n % RAND_W)) t = {t[RAND_W-2:0], t[RAND_W-1]};
    return t;
  endfunction

  // Saturate the widened score sum to the output width.
  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W+3:0] s);
    if (|s[SCORE_W+3:SCORE_W]) return '1;
    else                       return s[SCORE_W-1:0];
  endfunction

  tube_lfsr #(.RAND_W(RAND_W)) u_lfsr (
    .clk_10 (clk_10),
    .clr    (clr),
    .value  (w_rand)
  );

`ifdef TUBE_DIFFICULTY_RAMP_EN
  localparam int LW = ((SCORE_W > SPEED_W) ? SCORE_W : SPEED_W) + 1;
  localparam logic [SPEED_W-1:0] SPD_MAX = '1;
  logic [SCORE_W-1:0] r_level;
  logic [LW-1:0]      w_spd_sum;

  assign w_spd_sum = LW'(speed) + LW'(r_level);
  assign w_speed   = (w_spd_sum > LW'(SPD_MAX)) ? SPD_MAX : w_spd_sum[SPEED_W-1:0];

  // Level follows the score it is derived from, cleared on any restart.
  always_ff @(posedge clk_10) begin
    if (clr || w_reinit) r_level <= '0;
    else if (w_step)     r_level <= w_score_nxt / SCORE_W'(LEVEL_STEP);
  end
`else
  assign w_speed = speed;
`endif

  // Next state and step/restart strobes; over outranks start and pause.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_reinit    = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        if (over)        w_state_nxt = HALT;
        else if (!pause) w_step      = 1'b1;
      end
      HALT: begin
        if (start) begin
          w_state_nxt = RUN;
          w_reinit    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus registered running flag.
  always_ff @(posedge clk_10) begin
    if (clr) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // Per-tube step: respawn when the move would cross the left boundary.
  always_comb begin
    w_lim = (XW+1)'(X_LEFT) + (XW+1)'(w_speed);
    w_hit = '0;
    for (int i = 0; i < NUM_TUBES; i++) begin
      w_hit[i]   = ({1'b0, r_x[i]} < w_lim);
      w_x_nxt[i] = w_hit[i] ? XW'(X_RIGHT) : (r_x[i] - XW'(w_speed));
      w_y_nxt[i] = XW'(Y_BASE) + XW'(rotl(w_rand, i));
    end
  end

  // Score increments by the number of tubes respawning this step.
  always_comb begin
    w_sum = (SCORE_W+4)'(r_score);
    for (int i = 0; i < NUM_TUBES; i++)
      w_sum = w_sum + (SCORE_W+4)'(w_hit[i]);
    w_score_nxt = sat_score(w_sum);
  end

  // Tube positions, respawn pulses and score.
  always_ff @(posedge clk_10) begin
    if (clr || w_reinit) begin
      for (int i = 0; i < NUM_TUBES; i++) begin
        r_x[i] <= XW'(X0 + i * SPACING);
        r_y[i] <= XW'(Y_DEFAULT);
      end
      r_respawn <= '0;
      r_score   <= '0;
    end else if (w_step) begin
      for (int i = 0; i < NUM_TUBES; i++) begin
        r_x[i] <= w_x_nxt[i];
        if (w_hit[i]) r_y[i] <= w_y_nxt[i];
      end
      r_respawn <= w_hit;
      r_score   <= w_score_nxt;
    end else begin
      r_respawn <= '0;
    end
  end

  for (genvar g = 0; g < NUM_TUBES; g++) begin : g_out
    assign x_flat[g*XW +: XW] = r_x[g];
    assign y_flat[g*XW +: XW] = r_y[g];
  end

  assign respawn = r_respawn;
  assign score   = r_score;
  assign running = r_running;

endmodule

// File: tb/tb_tube_scroller.sv
// Directed bench for tube_scroller: default instance A for reset, scroll,
// stall, respawn, halt/restart; instance B (all tubes at x=111, 2-bit score)
// for simultaneous respawn and score saturation.
module tb_tube_scroller;

  logic        clk_10 = 1'b0;
  logic        clr, start, over, pause;
  logic [2:0]  speed;
  logic [29:0] a_x, a_y;
  logic [2:0]  a_resp;
  logic [9:0]  a_score;
  logic        a_run;

  logic        b_start, b_over, b_pause;
  logic [2:0]  b_speed;
  logic [29:0] b_x, b_y;
  logic [2:0]  b_resp;
  logic [1:0]  b_score;
  logic        b_run;

  logic [6:0]  m_lfsr;
  logic [6:0]  m_prev;
  int          nrun = 0;
  int          nfail = 0;
  logic        found;
  logic [9:0]  y0, y1, y2;

  always #5 clk_10 = ~clk_10;

  tube_scroller u_a (
    .clk_10 (clk_10), .clr (clr), .start (start), .over (over),
    .pause (pause), .speed (speed), .x_flat (a_x), .y_flat (a_y),
    .respawn (a_resp), .score (a_score), .running (a_run)
  );

  tube_scroller #(.X0(111), .SPACING(0), .SCORE_W(2)) u_b (
    .clk_10 (clk_10), .clr (clr), .start (b_start), .over (b_over),
    .pause (b_pause), .speed (b_speed), .x_flat (b_x), .y_flat (b_y),
    .respawn (b_resp), .score (b_score), .running (b_run)
  );

  // Reference LFSR: x^7+x^6+1, seed 7'h5A, advancing on every non-reset edge.
  always @(posedge clk_10) begin
    if (clr) m_lfsr <= 7'h5A;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  function automatic logic [6:0] rotl7(input logic [6:0] v, input int n);
    logic [6:0] t;
    t = v;
    for (int k = 0; k < n; k++) t = {t[5:0], t[6]};
    return t;
  endfunction

  task automatic tick();
    m_prev = m_lfsr;
    @(posedge clk_10);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nrun++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; over = 1'b0; pause = 1'b0; speed = 3'd1;
    b_start = 1'b0; b_over = 1'b0; b_pause = 1'b0; b_speed = 3'd0;
    #1;
    tick(); tick();
    clr = 1'b0;
    check("rst_x",    64'(a_x),     64'({10'd800, 10'd560, 10'd320}));
    check("rst_y",    64'(a_y),     64'({10'd240, 10'd240, 10'd240}));
    check("rst_score", 64'(a_score), 64'(0));
    check("rst_run",  64'(a_run),   64'(0));
    check("rst_resp", 64'(a_resp),  64'(0));

    repeat (20) tick();
    check("idle_x",   64'(a_x),     64'({10'd800, 10'd560, 10'd320}));
    check("idle_run", 64'(a_run),   64'(0));

    // IDLE -> RUN: no movement on the transition edge.
    start = 1'b1; tick(); start = 1'b0;
    check("start_run", 64'(a_run), 64'(1));
    check("start_x",   64'(a_x),   64'({10'd800, 10'd560, 10'd320}));

    repeat (10) tick();
    check("scroll10_x",    64'(a_x),    64'({10'd790, 10'd550, 10'd310}));
    check("scroll10_resp", 64'(a_resp), 64'(0));

    // Speed 0: stationary, LFSR keeps running (seen later in y0).
    speed = 3'd0;
    repeat (5) tick();
    check("stall_x", 64'(a_x), 64'({10'd790, 10'd550, 10'd310}));

    pause = 1'b1; speed = 3'd1;
    repeat (3) tick();
    check("pause_x", 64'(a_x), 64'({10'd790, 10'd550, 10'd310}));
    pause = 1'b0;

    repeat (200) tick();
    check("pre_resp_x",     64'(a_x),     64'({10'd590, 10'd350, 10'd110}));
    check("pre_resp_score", 64'(a_score), 64'(0));

    tick();
    y0 = a_y[9:0];
    check("resp_x",     64'(a_x),     64'({10'd589, 10'd349, 10'd800}));
    check("resp_pulse", 64'(a_resp),  64'(3'b001));
    check("resp_score", 64'(a_score), 64'(1));
    check("resp_y0",    64'(y0),      64'(10'd150 + 10'(rotl7(m_prev, 0))));
    check("resp_y0_rng", 64'(y0 >= 10'd150 && y0 <= 10'd277), 64'(1));
    check("resp_y12",   64'(a_y[29:10]), 64'({10'd240, 10'd240}));

    tick();
    check("post_resp_pulse", 64'(a_resp),  64'(0));
    check("post_resp_x0",    64'(a_x[9:0]), 64'(799));

    // Boundary: x0=113 with speed 4 respawns because 113 < 114.
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    speed = 3'd1;
    repeat (207) tick();
    check("bnd_pre_x", 64'(a_x), 64'({10'd593, 10'd353, 10'd113}));
    speed = 3'd4;
    tick();
    check("bnd_x",     64'(a_x),    64'({10'd589, 10'd349, 10'd800}));
    check("bnd_pulse", 64'(a_resp), 64'(3'b001));

    // over together with start in RUN: over wins, everything freezes.
    speed = 3'd1;
    repeat (5) tick();
    check("pre_over_x", 64'(a_x), 64'({10'd584, 10'd344, 10'd795}));
    over = 1'b1; start = 1'b1; tick(); over = 1'b0; start = 1'b0;
    check("over_run",   64'(a_run),   64'(0));
    check("over_x",     64'(a_x),     64'({10'd584, 10'd344, 10'd795}));
    check("over_score", 64'(a_score), 64'(1));
    repeat (3) tick();
    check("halt_x",     64'(a_x),     64'({10'd584, 10'd344, 10'd795}));
    check("halt_resp",  64'(a_resp),  64'(0));
    check("halt_score", 64'(a_score), 64'(1));

    start = 1'b1; tick(); start = 1'b0;
    check("restart_x",     64'(a_x),     64'({10'd800, 10'd560, 10'd320}));
    check("restart_score", 64'(a_score), 64'(0));
    check("restart_run",   64'(a_run),   64'(1));
    tick();
    check("restart_step", 64'(a_x[9:0]), 64'(319));

    // clr beats start.
    clr = 1'b1; start = 1'b1; tick(); clr = 1'b0; start = 1'b0;
    check("clr_start_run", 64'(a_run), 64'(0));
    check("clr_start_x",   64'(a_x),   64'({10'd800, 10'd560, 10'd320}));
    tick();
    check("clr_idle_run", 64'(a_run), 64'(0));
    check("clr_idle_x",   64'(a_x),   64'({10'd800, 10'd560, 10'd320}));

    // Instance B: simultaneous respawn of all tubes, then saturation.
    clr = 1'b1; tick(); clr = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("b_run", 64'(b_run), 64'(1));
    b_speed = 3'd2;
    tick();
    y0 = b_y[9:0]; y1 = b_y[19:10]; y2 = b_y[29:20];
    check("b_all_pulse", 64'(b_resp),  64'(3'b111));
    check("b_all_score", 64'(b_score), 64'(3));
    check("b_all_x",     64'(b_x),     64'({10'd800, 10'd800, 10'd800}));
    check("b_y0", 64'(y0), 64'(10'd150 + 10'(rotl7(m_prev, 0))));
    check("b_y1", 64'(y1), 64'(10'd150 + 10'(rotl7(m_prev, 1))));
    check("b_y2", 64'(y2), 64'(10'd150 + 10'(rotl7(m_prev, 2))));
    check("b_y_distinct", 64'(y0 != y1 && y1 != y2 && y0 != y2), 64'(1));

    b_speed = 3'd7;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (b_resp != 3'b000) found = 1'b1;
    end
    check("b_second_resp_seen", 64'(found),   64'(1));
    check("b_second_pulse",     64'(b_resp),  64'(3'b111));
    check("b_sat_score",        64'(b_score), 64'(3));

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
